fetch_stage: RTL and testbench

- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC and drives the instruction bus request/response handshake.
- Presents one fetched instruction per cycle (pc, raw instruction, valid) to decode.
- Holds its output under downstream stall, buffers a late-arriving instruction in a one-entry skid buffer, and services redirects from execute/branch resolution, including discarding an in-flight response.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with PC, bus handshake, skid buffer and redirect handling
module fetch_stage #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ireq_valid,
  output logic [PC_W-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            dataF_valid,
  output logic [PC_W-1:0] dataF_pc,
  output logic [31:0]     dataF_instr
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] redir_q, redir_d;
  logic [31:0]     buf_q, buf_d;
  logic            dataF_valid_q, dataF_valid_d;
  logic [PC_W-1:0] dataF_pc_q, dataF_pc_d;
  logic [31:0]     dataF_instr_q, dataF_instr_d;

  // Redirect targets are always word aligned; low bits are dropped here.
  logic [PC_W-1:0] redir_tgt;
  assign redir_tgt = {redirect_pc[PC_W-1:2], 2'b00};

  // The request stays up (and stable on pc_q) in every state except HOLD.
  assign ireq_valid  = (state_q != HOLD);
  assign ireq_addr   = pc_q;
  assign dataF_valid = dataF_valid_q;
  assign dataF_pc    = dataF_pc_q;
  assign dataF_instr = dataF_instr_q;

  // Next-state logic: redirect first, then response/stall handling per state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redir_d       = redir_q;
    buf_d         = buf_q;
    dataF_valid_d = dataF_valid_q;
    dataF_pc_d    = dataF_pc_q;
    dataF_instr_d = dataF_instr_q;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          dataF_valid_d = 1'b0;
          buf_d         = '0;
          if (iresp_data_ok) begin
            // Outstanding response completes now and is dropped.
            pc_d = redir_tgt;
          end else begin
            // Request must stay on the old PC until it completes.
            redir_d = redir_tgt;
            state_d = DISCARD;
          end
        end else if (iresp_data_ok) begin
          if (!stall) begin
            dataF_valid_d = 1'b1;
            dataF_pc_d    = pc_q;
            dataF_instr_d = iresp_data;
            pc_d          = pc_q + PC_STEP;
          end else begin
            buf_d   = iresp_data;
            state_d = HOLD;
          end
        end else if (!stall) begin
          dataF_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          dataF_valid_d = 1'b0;
          buf_d         = '0;
          pc_d          = redir_tgt;
          state_d       = FETCH;
        end else if (!stall) begin
          dataF_valid_d = 1'b1;
          dataF_pc_d    = pc_q;
          dataF_instr_d = buf_q;
          pc_d          = pc_q + PC_STEP;
          state_d       = FETCH;
        end
      end

      DISCARD: begin
        dataF_valid_d = 1'b0;
        if (redirect_valid) begin
          buf_d = '0;
          if (iresp_data_ok) begin
            pc_d    = redir_tgt;
            state_d = FETCH;
          end else begin
            redir_d = redir_tgt;
          end
        end else if (iresp_data_ok) begin
          pc_d    = redir_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and output registers, asynchronously reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      redir_q       <= '0;
      buf_q         <= '0;
      dataF_valid_q <= 1'b0;
      dataF_pc_q    <= '0;
      dataF_instr_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redir_q       <= redir_d;
      buf_q         <= buf_d;
      dataF_valid_q <= dataF_valid_d;
      dataF_pc_q    <= dataF_pc_d;
      dataF_instr_q <= dataF_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        dataF_valid;
  logic [63:0] dataF_pc;
  logic [31:0] dataF_instr;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .PC_W     (64),
    .RESET_PC (64'h8000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dataF_valid    (dataF_valid),
    .dataF_pc       (dataF_pc),
    .dataF_instr    (dataF_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report any mismatch.
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] instr);
    check_eq({tag, ".valid"}, {63'd0, dataF_valid}, {63'd0, v});
    if (v) begin
      check_eq({tag, ".pc"}, dataF_pc, pc);
      check_eq({tag, ".instr"}, {32'd0, dataF_instr}, {32'd0, instr});
    end
  endtask

  task automatic check_req(input string tag, input logic v, input logic [63:0] addr);
    check_eq({tag, ".ireq_valid"}, {63'd0, ireq_valid}, {63'd0, v});
    if (v) check_eq({tag, ".ireq_addr"}, ireq_addr, addr);
  endtask

  // Drive one cycle of inputs at the falling edge; return 1ns after the rising edge.
  task automatic cycle(input logic ok, input logic [31:0] data, input logic st,
                       input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    iresp_data_ok  = ok;
    iresp_data     = data;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.valid", {63'd0, dataF_valid}, 64'd0);
    check_eq("rst.pc", dataF_pc, 64'd0);
    check_eq("rst.instr", {32'd0, dataF_instr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_req("rel", 1'b1, 64'h8000_0000);

    // Back-to-back fetch
    cycle(1'b1, 32'h0000_0011, 1'b0, 1'b0, 64'd0);
    check_out("bb0", 1'b1, 64'h8000_0000, 32'h0000_0011);
    check_req("bb0", 1'b1, 64'h8000_0004);

    // Stall while the response returns: skid and hold
    cycle(1'b1, 32'h0000_0013, 1'b1, 1'b0, 64'd0);
    check_out("stl0", 1'b1, 64'h8000_0000, 32'h0000_0011);
    check_req("stl0", 1'b0, 64'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 64'd0);
    check_out("stl1", 1'b1, 64'h8000_0000, 32'h0000_0011);
    check_req("stl1", 1'b0, 64'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'd0);
    check_out("stl2", 1'b1, 64'h8000_0004, 32'h0000_0013);
    check_req("stl2", 1'b1, 64'h8000_0008);

    // Redirect with a request pending
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_1000);
    check_out("rd0", 1'b0, 64'd0, 32'd0);
    check_req("rd0", 1'b1, 64'h8000_0008);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'd0);
    check_out("rd1", 1'b0, 64'd0, 32'd0);
    check_req("rd1", 1'b1, 64'h8000_0008);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'd0);
    check_out("rd2", 1'b0, 64'd0, 32'd0);
    check_req("rd2", 1'b1, 64'h8000_1000);
    cycle(1'b1, 32'h0000_0021, 1'b0, 1'b0, 64'd0);
    check_out("rd3", 1'b1, 64'h8000_1000, 32'h0000_0021);
    check_req("rd3", 1'b1, 64'h8000_1004);

    // Two redirects in one discard window; low address bits forced to zero
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h100);
    check_req("dr0", 1'b1, 64'h8000_1004);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 64'h202);
    check_out("dr1", 1'b0, 64'd0, 32'd0);
    check_req("dr1", 1'b1, 64'h8000_1004);
    cycle(1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 64'd0);
    check_out("dr2", 1'b0, 64'd0, 32'd0);
    check_req("dr2", 1'b1, 64'h200);
    cycle(1'b1, 32'h0000_0031, 1'b0, 1'b0, 64'd0);
    check_out("dr3", 1'b1, 64'h200, 32'h0000_0031);
    check_req("dr3", 1'b1, 64'h204);

    // Redirect together with stall while holding a skid instruction
    cycle(1'b1, 32'h0000_0041, 1'b1, 1'b0, 64'd0);
    check_out("hr0", 1'b1, 64'h200, 32'h0000_0031);
    check_req("hr0", 1'b0, 64'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 64'h300);
    check_out("hr1", 1'b0, 64'd0, 32'd0);
    check_req("hr1", 1'b1, 64'h300);
    cycle(1'b1, 32'h0000_0051, 1'b0, 1'b0, 64'd0);
    check_out("hr2", 1'b1, 64'h300, 32'h0000_0051);
    check_req("hr2", 1'b1, 64'h304);

    // Redirect coinciding with a response, then PC wrap
    cycle(1'b1, 32'h0000_0061, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_out("wr0", 1'b0, 64'd0, 32'd0);
    check_req("wr0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b1, 32'h0000_0071, 1'b0, 1'b0, 64'd0);
    check_out("wr1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0071);
    check_req("wr1", 1'b1, 64'h0);
    cycle(1'b1, 32'h0000_0081, 1'b0, 1'b0, 64'd0);
    check_out("wr2", 1'b1, 64'h0, 32'h0000_0081);
    check_req("wr2", 1'b1, 64'h4);

    // Bubble when no response and no stall
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 64'd0);
    check_out("bub", 1'b0, 64'd0, 32'd0);
    check_req("bub", 1'b1, 64'h4);

    // Reset pulse mid-request
    cycle(1'b1, 32'h0000_00A1, 1'b0, 1'b0, 64'd0);
    check_out("pre", 1'b1, 64'h4, 32'h0000_00A1);
    @(negedge clk);
    iresp_data_ok = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("mrst.valid", {63'd0, dataF_valid}, 64'd0);
    check_eq("mrst.pc", dataF_pc, 64'd0);
    check_eq("mrst.instr", {32'd0, dataF_instr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_req("mrst", 1'b1, 64'h8000_0000);
    cycle(1'b1, 32'h0000_0091, 1'b0, 1'b0, 64'd0);
    check_out("post", 1'b1, 64'h8000_0000, 32'h0000_0091);
    check_req("post", 1'b1, 64'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
